// File: rtl/add_accum_sat_if.sv
// Handshake bundle between the adder stage, the saturating frame accumulator and its consumer.
interface add_accum_sat_if #(
  parameter int DW    = 18,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_sum;
  logic             in_carry;
  logic [CNT_W-1:0] acc_len;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_sum, in_carry, acc_len, clear, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_sum, in_carry, acc_len, clear, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/add_accum_sat.sv
// Saturating frame accumulator: clamps each {carry,sum} adder result to DW bits, sums
// acc_len samples with saturation and presents the total plus a sticky clamp flag.
module add_accum_sat #(
  parameter int DW    = 18,
  parameter int US    = 1,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  add_accum_sat_if.slave bus
);
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]       state;
  logic [DW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             sticky;
  logic [DW-1:0]    out_data_q;
  logic             out_sat_q;
  logic             out_valid_q;

  logic [DW-1:0]    sample;
  logic             in_clamp;
  logic [DW-1:0]    acc_new;
  logic             acc_clamp;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W:0]   cnt_inc;
  logic             last;

  assign bus.in_ready  = (state == ST_ACC) && !bus.clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  generate
    if (US != 0) begin : g_uns
      logic [DW:0] sum_w;
      always_comb begin
        in_clamp = bus.in_carry;
        sample   = bus.in_carry ? {DW{1'b1}} : bus.in_sum;
        sum_w    = {1'b0, acc} + {1'b0, sample};
        acc_clamp = sum_w[DW];
        acc_new   = sum_w[DW] ? {DW{1'b1}} : sum_w[DW-1:0];
      end
    end else begin : g_sgn
      logic [DW:0] sum_w;
      always_comb begin
        // Carry disagreeing with the sum MSB means the DW+1-bit value left the DW-bit range.
        in_clamp = bus.in_carry != bus.in_sum[DW-1];
        if (in_clamp)
          sample = bus.in_carry ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
          sample = bus.in_sum;
        sum_w     = {acc[DW-1], acc} + {sample[DW-1], sample};
        acc_clamp = sum_w[DW] != sum_w[DW-1];
        if (acc_clamp)
          acc_new = sum_w[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
          acc_new = sum_w[DW-1:0];
      end
    end
  endgenerate

  // Frame length is latched on the first accept; a zero length means one sample.
  assign len_eff = (cnt == '0) ? ((bus.acc_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.acc_len)
                               : len;
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last    = cnt_inc == {1'b0, len_eff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      acc         <= '0;
      cnt         <= '0;
      len         <= '0;
      sticky      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= ST_ACC;
      acc         <= '0;
      cnt         <= '0;
      sticky      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            if (cnt == '0) len <= len_eff;
            if (last) begin
              out_data_q  <= acc_new;
              out_sat_q   <= sticky | in_clamp | acc_clamp;
              out_valid_q <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              sticky      <= 1'b0;
              state       <= ST_OUT;
            end else begin
              acc    <= acc_new;
              cnt    <= cnt_inc[CNT_W-1:0];
              sticky <= sticky | in_clamp | acc_clamp;
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_ACC;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add_accum_sat.sv
// Directed bench: unsigned and signed accumulator instances driven from one linear sequence.
module tb_add_accum_sat;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  add_accum_sat_if #(.DW(18), .CNT_W(8)) ui ();
  add_accum_sat_if #(.DW(18), .CNT_W(8)) si ();

  add_accum_sat #(.DW(18), .US(1), .CNT_W(8)) dut_u (.clk(clk), .rst_n(rst_n), .bus(ui));
  add_accum_sat #(.DW(18), .US(0), .CNT_W(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(si));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_u(input logic [17:0] sum, input logic carry);
    ui.in_valid = 1'b1;
    ui.in_sum   = sum;
    ui.in_carry = carry;
    #1;
    chk("u_in_ready_before_accept", {31'd0, ui.in_ready}, 32'd1);
    tick();
    ui.in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [17:0] sum, input logic carry);
    si.in_valid = 1'b1;
    si.in_sum   = sum;
    si.in_carry = carry;
    #1;
    chk("s_in_ready_before_accept", {31'd0, si.in_ready}, 32'd1);
    tick();
    si.in_valid = 1'b0;
  endtask

  task automatic chk_out_u(input string tag, input logic [17:0] data, input logic sat);
    chk({tag, "_valid"}, {31'd0, ui.out_valid}, 32'd1);
    chk({tag, "_data"},  {14'd0, ui.out_data}, {14'd0, data});
    chk({tag, "_sat"},   {31'd0, ui.out_sat}, {31'd0, sat});
  endtask

  task automatic chk_out_s(input string tag, input logic [17:0] data, input logic sat);
    chk({tag, "_valid"}, {31'd0, si.out_valid}, 32'd1);
    chk({tag, "_data"},  {14'd0, si.out_data}, {14'd0, data});
    chk({tag, "_sat"},   {31'd0, si.out_sat}, {31'd0, sat});
  endtask

  task automatic drain_u();
    ui.out_ready = 1'b1;
    tick();
    ui.out_ready = 1'b0;
    chk("u_drain_valid", {31'd0, ui.out_valid}, 32'd0);
    chk("u_drain_ready", {31'd0, ui.in_ready}, 32'd1);
  endtask

  task automatic drain_s();
    si.out_ready = 1'b1;
    tick();
    si.out_ready = 1'b0;
    chk("s_drain_valid", {31'd0, si.out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ui.in_valid = 1'b0; ui.in_sum = '0; ui.in_carry = 1'b0; ui.acc_len = '0;
    ui.clear = 1'b0; ui.out_ready = 1'b0;
    si.in_valid = 1'b0; si.in_sum = '0; si.in_carry = 1'b0; si.acc_len = '0;
    si.clear = 1'b0; si.out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, ui.out_valid}, 32'd0);
    chk("rst_data",  {14'd0, ui.out_data}, 32'd0);
    chk("rst_ready", {31'd0, ui.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Plain unsigned frame, result one cycle after the last accept.
    ui.acc_len = 8'd4;
    send_u(18'd10, 1'b0);
    send_u(18'd20, 1'b0);
    send_u(18'd30, 1'b0);
    chk("u4_not_yet_valid", {31'd0, ui.out_valid}, 32'd0);
    send_u(18'd40, 1'b0);
    chk_out_u("u4", 18'd100, 1'b0);
    chk("u4_in_ready_out", {31'd0, ui.in_ready}, 32'd0);
    drain_u();

    // Input clamp on carry, then accumulator clamp.
    ui.acc_len = 8'd2;
    send_u(18'd5, 1'b1);
    send_u(18'd1, 1'b0);
    chk_out_u("u_clamp", 18'd262143, 1'b1);
    drain_u();

    // Backpressure with a pending sample that must not be consumed.
    send_u(18'd3, 1'b0);
    send_u(18'd4, 1'b0);
    ui.in_valid = 1'b1; ui.in_sum = 18'd99; ui.in_carry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", {31'd0, ui.in_ready}, 32'd0);
      chk("bp_data",  {14'd0, ui.out_data}, 32'd7);
      chk("bp_valid", {31'd0, ui.out_valid}, 32'd1);
    end
    ui.out_ready = 1'b1;
    tick();
    ui.in_valid = 1'b0;
    ui.out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, ui.out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, ui.in_ready}, 32'd1);
    ui.acc_len = 8'd1;
    send_u(18'd1, 1'b0);
    chk_out_u("bp_after", 18'd1, 1'b0);
    drain_u();

    // Clear aborts a frame; the sample offered alongside it is dropped.
    ui.acc_len = 8'd4;
    send_u(18'd5, 1'b0);
    send_u(18'd5, 1'b0);
    ui.in_valid = 1'b1; ui.in_sum = 18'd100; ui.clear = 1'b1;
    #1;
    chk("clr_in_ready", {31'd0, ui.in_ready}, 32'd0);
    tick();
    ui.clear = 1'b0; ui.in_valid = 1'b0;
    send_u(18'd1, 1'b0);
    ui.acc_len = 8'd2;
    send_u(18'd1, 1'b0);
    send_u(18'd1, 1'b0);
    chk("clr_len_held", {31'd0, ui.out_valid}, 32'd0);
    send_u(18'd1, 1'b0);
    chk_out_u("clr_after", 18'd4, 1'b0);
    // Clear wins over the output handshake and leaves the data visible.
    ui.clear = 1'b1; ui.out_ready = 1'b1;
    tick();
    ui.clear = 1'b0; ui.out_ready = 1'b0;
    chk("clr_out_valid", {31'd0, ui.out_valid}, 32'd0);
    chk("clr_out_data",  {14'd0, ui.out_data}, 32'd4);

    // Zero length means one sample.
    ui.acc_len = 8'd0;
    send_u(18'd7, 1'b0);
    chk_out_u("len0", 18'd7, 1'b0);
    drain_u();

    // Signed: accumulator clamps high, then recovers.
    si.acc_len = 8'd3;
    send_s(18'd100000, 1'b0);
    send_s(18'd100000, 1'b0);
    send_s(18'd212144, 1'b1);
    chk_out_s("s_acc_clamp", 18'd81071, 1'b1);
    drain_s();
    // Signed negative input clamp.
    si.acc_len = 8'd1;
    send_s(18'd5, 1'b1);
    chk_out_s("s_in_clamp_neg", 18'd131072, 1'b1);
    drain_s();
    // Signed positive input clamp.
    send_s(18'd131072, 1'b0);
    chk_out_s("s_in_clamp_pos", 18'd131071, 1'b1);
    drain_s();
    // Signed negatives without clamp: -3 + -4 = -7.
    si.acc_len = 8'd2;
    send_s(18'd262141, 1'b1);
    send_s(18'd262140, 1'b1);
    chk_out_s("s_neg", 18'd262137, 1'b0);
    drain_s();

    // Asynchronous reset mid-frame.
    ui.acc_len = 8'd4;
    send_u(18'd1, 1'b0);
    send_u(18'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, ui.out_valid}, 32'd0);
    chk("mid_rst_data",  {14'd0, ui.out_data}, 32'd0);
    chk("mid_rst_sat",   {31'd0, ui.out_sat}, 32'd0);
    chk("mid_rst_ready", {31'd0, ui.in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_u(18'd1, 1'b0);
    chk_out_u("post_rst", 18'd4, 1'b0);
    drain_u();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/add_accum_sat.md
# add_accum_sat

Saturating frame accumulator that sits directly downstream of the combinational adder stage. It consumes the adder's `{carry, sum}` result one sample per accepted handshake and clamps each sample to DW bits. It accumulates `acc_len` samples with saturating arithmetic, then presents the frame total on a valid/ready output. It also reports whether any clamp occurred during the frame.

## Interface

Parameters:
- `DW`, 18: data width; matches the adder's `sum` width.
- `US`, 1: 1 = unsigned arithmetic, 0 = two's-complement signed; must match the upstream adder setting.
- `CNT_W`, 8: width of the frame-length input and the sample counter.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: upstream adder result is valid.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `in_sum`, in, DW: adder `sum`.
- `in_carry`, in, 1: adder `carry` (the MSB of the DW+1-bit result).
- `acc_len`, in, CNT_W: samples per frame; sampled on the first accept of each frame.
- `clear`, in, 1: synchronous abort of the current frame and any pending result.
- `out_valid`, out, 1: frame total available.
- `out_ready`, in, 1: downstream accepts the total.
- `out_data`, out, DW: saturated frame total.
- `out_sat`, out, 1: at least one input clamp or accumulator clamp occurred in this frame.

## Operation

- Two states:
  - ACC: collecting samples; `in_ready` = 1 unless `clear` is high.
  - OUT: holding the result; `in_ready` = 0.
- Accept condition: `in_valid & in_ready`.
- Input clamp, unsigned (US=1):
  - Value = `{in_carry, in_sum}`.
  - If `in_carry` = 1, the sample becomes 2^DW−1 and the clamp is flagged.
- Input clamp, signed (US=0):
  - Value = `{in_carry, in_sum}` read as DW+1-bit two's complement.
  - If `in_carry` ≠ `in_sum[DW-1]`, the sample becomes +2^(DW−1)−1 when `in_carry` = 0, or −2^(DW−1) when `in_carry` = 1, and the clamp is flagged.
- Accumulation: `new = sat(acc + sample)`, computed DW+1 bits wide and clamped to the US range; a clamp sets the sticky frame flag.
- The first sample of a frame uses acc = 0. The effective frame length is captured from `acc_len` at that accept; `acc_len` = 0 is treated as 1. Later changes to `acc_len` do not affect the frame in progress.
- On the final accept (count + 1 = length):
  - `out_data` ← new;
  - `out_sat` ← sticky flag OR clamp this cycle;
  - `out_valid` ← 1;
  - acc, count and the sticky flag reset to 0;
  - state → OUT.
- OUT: `out_data`, `out_sat` and `out_valid` hold stable until `out_valid & out_ready`. On that handshake `out_valid` ← 0 and state → ACC; `out_data` and `out_sat` keep their last values.
- `clear` (either state): acc, count and the sticky flag ← 0; `out_valid` ← 0; state → ACC.
  - `clear` has priority over `in_valid` and over the output handshake.
  - `in_ready` is forced to 0 in any cycle where `clear` is high, so no sample is consumed.
- Reset: state ACC, acc/count/flag 0, `out_valid` 0, `out_data` 0, `out_sat` 0. `in_ready` is 1 from the first cycle after release (and during reset, it is combinational from state).

## Timing

- `in_ready` is combinational from state and `clear` only; it has no path from `in_valid`.
- Result latency: `out_valid` rises in the cycle after the final sample is accepted.
- Throughput: one sample per cycle within a frame, plus a minimum of 1 OUT cycle per frame. With `out_ready` held at 1, a frame of N samples occupies N+1 cycles.
- The output handshake completes on the edge where `out_valid & out_ready`. `in_ready` returns to 1 in the following cycle.
- Asserting reset mid-frame or mid-OUT discards all partial data immediately (asynchronous reset).

## Test plan

- Reset: drive `rst_n` low after 2 of 4 samples → `out_valid`/`out_data`/`out_sat` = 0 and `in_ready` = 1. A fresh frame 1,1,1,1 then gives `out_data` = 4.
- US=1, DW=18, `acc_len` = 4, samples 10, 20, 30, 40 with carry 0 → `out_data` = 100, `out_sat` = 0, `out_valid` one cycle after the 4th accept.
- US=1, `acc_len` = 2: first sample carry = 1, sum = 5; second sample 1 → `out_data` = 262143, `out_sat` = 1.
- US=0, `acc_len` = 3, samples 100000, 100000, −50000 → accumulator clamps to 131071 after the 2nd sample; `out_data` = 81071, `out_sat` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 → `out_data` stable, `in_ready` = 0, no samples consumed. Raise `out_ready` → handshake completes, `in_ready` = 1 next cycle.
- `clear` after 2 of 4 samples (with `in_valid` high) → that sample is not consumed. Then 4 samples of 1 → `out_data` = 4. Also check `acc_len` = 0 with a single sample of 7 → `out_data` = 7.
